sseg_scan_arbiter: RTL and testbench

Display scheduler for the 4-digit multiplexed seven-segment display. It time-multiplexes the four digits at a programmable scan rate and decodes BCD to active-low segment codes. It arbitrates display ownership between three requesters (setup editor, message/seconds view, normal time view), switching only at frame boundaries. It also blinks the digit being edited. It sits between the timekeeping/setup logic and the board pins IO_SSEG/IO_SSEGD/IO_SSEG_COL.

---
 rtl/sseg_scan_arbiter_if.sv | 56 +++++
 rtl/sseg_scan_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_sseg_scan_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sseg_scan_arbiter_if.sv
// ----------------------------------------------------------------------------
// sseg_scan_arbiter_if
// Request/data bundle between the display requesters and the display
// scheduler. The requesters (setup editor, message view, time view) sit on the
// master side; the scheduler sits on the slave side.
//
// Signals:
//   edit_req   editor requests the display (highest priority)
//   edit_bcd   editor digits, nibble k = digit k
//   edit_sel   index of the digit being edited (blinked)
//   msg_req    message/seconds view request
//   msg_bcd    message digits
//   time_req   normal time view request (lowest priority)
//   time_bcd   time digits, digit 0 = hours tens
//   time_colon colon request from the time view, 1 = lit
//   grant      one-hot owner: [2] edit, [1] msg, [0] time, 000 = none
//   frame_done one-cycle pulse at each frame boundary
// ----------------------------------------------------------------------------
interface sseg_scan_arbiter_if;
    logic        edit_req;
    logic [15:0] edit_bcd;
    logic [1:0]  edit_sel;
    logic        msg_req;
    logic [15:0] msg_bcd;
    logic        time_req;
    logic [15:0] time_bcd;
    logic        time_colon;
    logic [2:0]  grant;
    logic        frame_done;

    modport master (
        output edit_req,
        output edit_bcd,
        output edit_sel,
        output msg_req,
        output msg_bcd,
        output time_req,
        output time_bcd,
        output time_colon,
        input  grant,
        input  frame_done
    );

    modport slave (
        input  edit_req,
        input  edit_bcd,
        input  edit_sel,
        input  msg_req,
        input  msg_bcd,
        input  time_req,
        input  time_bcd,
        input  time_colon,
        output grant,
        output frame_done
    );
endinterface

// File: rtl/sseg_scan_arbiter.sv
// ----------------------------------------------------------------------------
// sseg_scan_arbiter
// Display scheduler for a 4-digit multiplexed seven-segment display. Scans the
// digits at a programmable rate, decodes BCD to active-low segments, hands the
// display to one of three requesters (edit > msg > time) only at frame
// boundaries, and blinks the digit being edited.
//
// Parameters:
//   SCAN_DIV    scan counter terminal count; each digit lit SCAN_DIV+1 cycles
//   BLINK_DIV   blink counter terminal count; phase toggles every BLINK_DIV+1
//
// Ports:
//   M_CLOCK      system clock
//   M_RESET_N    asynchronous active-low reset
//   bus          requester bundle (slave side): requests, digit buses, grant,
//                frame_done
//   IO_SSEG      segment drive, active-low, bit 7 = dot (always off)
//   IO_SSEGD     digit enables, active-low, bit k = digit k
//   IO_SSEG_COL  colon, active-low
// ----------------------------------------------------------------------------
module sseg_scan_arbiter #(
    parameter int unsigned SCAN_DIV  = 49999,
    parameter int unsigned BLINK_DIV = 24999999
) (
    input  logic                M_CLOCK,
    input  logic                M_RESET_N,
    sseg_scan_arbiter_if.slave  bus,
    output logic [7:0]          IO_SSEG,
    output logic [3:0]          IO_SSEGD,
    output logic                IO_SSEG_COL
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 0) ? $clog2(SCAN_DIV + 1)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 0) ? $clog2(BLINK_DIV + 1) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_TC  = SCAN_W'(SCAN_DIV);
    localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_DIV);

    // Owner encoding equals the one-hot grant value, so grant is the state
    // register itself.
    typedef enum logic [2:0] {
        StNone = 3'b000,
        StTime = 3'b001,
        StMsg  = 3'b010,
        StEdit = 3'b100
    } owner_e;

    owner_e               r_owner;
    owner_e               w_owner_d;
    logic [SCAN_W-1:0]    r_scan_cnt;
    logic [SCAN_W-1:0]    w_scan_cnt_d;
    logic [1:0]           r_idx;
    logic [1:0]           w_idx_d;
    logic [BLINK_W-1:0]   r_blink_cnt;
    logic [BLINK_W-1:0]   w_blink_cnt_d;
    logic                 r_blink_phase;
    logic                 w_blink_phase_d;
    logic                 r_frame_done;
    logic [7:0]           r_sseg;
    logic [7:0]           w_sseg_d;
    logic [3:0]           r_ssegd;
    logic [3:0]           w_ssegd_d;
    logic                 r_col;
    logic                 w_col_d;

    logic                 w_scan_tc;
    logic                 w_boundary;
    logic                 w_edit_enter;
    logic [15:0]          w_src_bcd;
    logic [3:0]           w_nibble;

    // BCD to active-low segments, dot off. 10..14 show a dash, 15 is blank.
    function automatic logic [7:0] f_decode(input logic [3:0] nib);
        logic [7:0] seg;
        unique case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h98;
            4'd15:   seg = 8'hFF;
            default: seg = 8'hBF;
        endcase
        return seg;
    endfunction

    assign w_scan_tc  = (r_scan_cnt == SCAN_TC);
    assign w_boundary = w_scan_tc && (r_idx == 2'd3);

    // ------------------------------------------------------------------------
    // Scan counter and digit index
    // ------------------------------------------------------------------------
    always_comb begin
        w_scan_cnt_d = r_scan_cnt + SCAN_W'(1);
        w_idx_d      = r_idx;
        if (w_scan_tc) begin
            w_scan_cnt_d = '0;
            w_idx_d      = r_idx + 2'd1;
        end
    end

    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd3;
        end else begin
            r_scan_cnt <= w_scan_cnt_d;
            r_idx      <= w_idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Ownership FSM: only re-evaluated on the 3->0 wrap, so a dropped request
    // keeps the display until the next boundary and nobody is pre-empted.
    // ------------------------------------------------------------------------
    always_comb begin
        w_owner_d = r_owner;
        if (w_boundary) begin
            if (bus.edit_req) begin
                w_owner_d = StEdit;
            end else if (bus.msg_req) begin
                w_owner_d = StMsg;
            end else if (bus.time_req) begin
                w_owner_d = StTime;
            end else begin
                w_owner_d = StNone;
            end
        end
    end

    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            r_owner      <= StNone;
            r_frame_done <= 1'b0;
        end else begin
            r_owner      <= w_owner_d;
            r_frame_done <= w_boundary;
        end
    end

    assign bus.grant      = r_owner;
    assign bus.frame_done = r_frame_done;

    // ------------------------------------------------------------------------
    // Blink timebase. Restarted when edit newly takes the display so the
    // edited digit is visible for a full half-period first.
    // ------------------------------------------------------------------------
    assign w_edit_enter = w_boundary && (w_owner_d == StEdit) && (r_owner != StEdit);

    always_comb begin
        w_blink_cnt_d   = r_blink_cnt + BLINK_W'(1);
        w_blink_phase_d = r_blink_phase;
        if (w_edit_enter) begin
            w_blink_cnt_d   = '0;
            w_blink_phase_d = 1'b0;
        end else if (r_blink_cnt == BLINK_TC) begin
            w_blink_cnt_d   = '0;
            w_blink_phase_d = ~r_blink_phase;
        end
    end

    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_blink_cnt   <= w_blink_cnt_d;
            r_blink_phase <= w_blink_phase_d;
        end
    end

    // ------------------------------------------------------------------------
    // Display data for the digit about to be lit. Everything is computed from
    // the next-state owner/index/phase so that enable, segments and colon all
    // change on the same edge, including the boundary edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_src_bcd = 16'hFFFF;
        case (w_owner_d)
            StEdit:  w_src_bcd = bus.edit_bcd;
            StMsg:   w_src_bcd = bus.msg_bcd;
            StTime:  w_src_bcd = bus.time_bcd;
            default: w_src_bcd = 16'hFFFF;
        endcase
    end

    always_comb begin
        w_nibble = w_src_bcd[3:0];
        unique case (w_idx_d)
            2'd0: w_nibble = w_src_bcd[3:0];
            2'd1: w_nibble = w_src_bcd[7:4];
            2'd2: w_nibble = w_src_bcd[11:8];
            2'd3: w_nibble = w_src_bcd[15:12];
        endcase
    end

    always_comb begin
        w_sseg_d  = f_decode(w_nibble);
        w_ssegd_d = ~(4'b0001 << w_idx_d);
        w_col_d   = 1'b1;
        case (w_owner_d)
            StEdit: begin
                w_col_d = 1'b0;
                if (w_blink_phase_d) begin
                    w_ssegd_d[bus.edit_sel] = 1'b1;
                end
            end
            StTime: begin
                w_col_d = ~bus.time_colon;
            end
            StMsg: begin
                w_col_d = 1'b1;
            end
            default: begin
                // Nobody owns the display: blank it, scanning continues.
                w_sseg_d  = 8'hFF;
                w_ssegd_d = 4'hF;
                w_col_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            r_sseg  <= 8'hFF;
            r_ssegd <= 4'hF;
            r_col   <= 1'b1;
        end else if (w_scan_tc) begin
            r_sseg  <= w_sseg_d;
            r_ssegd <= w_ssegd_d;
            r_col   <= w_col_d;
        end
    end

    assign IO_SSEG     = r_sseg;
    assign IO_SSEGD    = r_ssegd;
    assign IO_SSEG_COL = r_col;

endmodule

// File: tb/tb_sseg_scan_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sseg_scan_arbiter
// Directed bench for sseg_scan_arbiter with SCAN_DIV = 3, BLINK_DIV = 9.
// Expected display states are queued as stimulus is applied and compared at
// each digit advance.
// ----------------------------------------------------------------------------
module tb_sseg_scan_arbiter;

    typedef struct packed {
        logic [2:0] grant;
        logic       fd;
        logic [3:0] ssegd;
        logic [7:0] sseg;
        logic       col;
    } exp_t;

    logic       M_CLOCK;
    logic       M_RESET_N;
    logic [7:0] IO_SSEG;
    logic [3:0] IO_SSEGD;
    logic       IO_SSEG_COL;

    int n_assert;
    int n_fail;
    exp_t q[$];

    sseg_scan_arbiter_if u_if ();

    sseg_scan_arbiter #(
        .SCAN_DIV  (3),
        .BLINK_DIV (9)
    ) u_dut (
        .M_CLOCK     (M_CLOCK),
        .M_RESET_N   (M_RESET_N),
        .bus         (u_if.slave),
        .IO_SSEG     (IO_SSEG),
        .IO_SSEGD    (IO_SSEGD),
        .IO_SSEG_COL (IO_SSEG_COL)
    );

    initial begin
        M_CLOCK = 1'b0;
        forever #5 M_CLOCK = ~M_CLOCK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge M_CLOCK);
        #1;
    endtask

    task automatic push(input logic [2:0] g, input logic fd, input logic [3:0] en,
                        input logic [7:0] seg, input logic col);
        exp_t e;
        e.grant = g;
        e.fd    = fd;
        e.ssegd = en;
        e.sseg  = seg;
        e.col   = col;
        q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        n_assert++;
        assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
            return;
        end
        e = q.pop_front();
        chk($sformatf("%s.grant", tag), 32'(u_if.grant), 32'(e.grant));
        chk($sformatf("%s.frame_done", tag), 32'(u_if.frame_done), 32'(e.fd));
        chk($sformatf("%s.ssegd", tag), 32'(IO_SSEGD), 32'(e.ssegd));
        chk($sformatf("%s.sseg", tag), 32'(IO_SSEG), 32'(e.sseg));
        chk($sformatf("%s.col", tag), 32'(IO_SSEG_COL), 32'(e.col));
    endtask

    // One digit period, then compare against the oldest queued expectation.
    task automatic adv(input string tag);
        repeat (4) tick();
        pop_check(tag);
    endtask

    initial begin
        logic [3:0] en;
        logic       ph;
        int         dig;
        int         m;

        n_assert = 0;
        n_fail   = 0;

        M_RESET_N        = 1'b0;
        u_if.edit_req    = 1'b0;
        u_if.edit_bcd    = 16'h0000;
        u_if.edit_sel    = 2'd2;
        u_if.msg_req     = 1'b0;
        u_if.msg_bcd     = 16'h3210;
        u_if.time_req    = 1'b1;
        u_if.time_bcd    = 16'h4321;
        u_if.time_colon  = 1'b1;

        repeat (2) tick();
        chk("rst.sseg", 32'(IO_SSEG), 32'h0FF);
        chk("rst.ssegd", 32'(IO_SSEGD), 32'hF);
        chk("rst.col", 32'(IO_SSEG_COL), 32'd1);
        chk("rst.grant", 32'(u_if.grant), 32'd0);
        chk("rst.fd", 32'(u_if.frame_done), 32'd0);
        M_RESET_N = 1'b1;

        // Scan order: time view showing 1234 with colon lit.
        push(3'b001, 1'b1, 4'b1110, 8'hF9, 1'b0);
        push(3'b001, 1'b0, 4'b1101, 8'hA4, 1'b0);
        push(3'b001, 1'b0, 4'b1011, 8'hB0, 1'b0);
        push(3'b001, 1'b0, 4'b0111, 8'h99, 1'b0);
        push(3'b001, 1'b1, 4'b1110, 8'hF9, 1'b0);
        for (int i = 0; i < 5; i++) adv($sformatf("scan%0d", i));

        // Decode edges: digits A F 9 0, colon off.
        u_if.time_bcd   = 16'h09FA;
        u_if.time_colon = 1'b0;
        push(3'b001, 1'b0, 4'b1101, 8'hFF, 1'b1);
        push(3'b001, 1'b0, 4'b1011, 8'h98, 1'b1);
        push(3'b001, 1'b0, 4'b0111, 8'hC0, 1'b1);
        for (int i = 0; i < 3; i++) adv($sformatf("dec%0d", i));

        // Boundary-only switching: edit raised while digit 1 is lit.
        u_if.time_bcd = 16'h8765;
        push(3'b001, 1'b1, 4'b1110, 8'h92, 1'b1);
        push(3'b001, 1'b0, 4'b1101, 8'h82, 1'b1);
        adv("sw0");
        adv("sw1");
        u_if.edit_req = 1'b1;
        push(3'b001, 1'b0, 4'b1011, 8'hF8, 1'b1);
        push(3'b001, 1'b0, 4'b0111, 8'h80, 1'b1);
        adv("sw2");
        adv("sw3");

        // Edit owns from advance 0 of this loop; blink phase restarts there.
        // Msg joins at advance 20, edit drops at advance 25 (mid-frame).
        for (int n = 0; n <= 27; n++) begin
            dig = n % 4;
            ph  = ((4 * n) / 10) % 2 == 1;
            en  = ~(4'b0001 << dig);
            if (ph && dig == 2) en = 4'hF;
            push(3'b100, dig == 0, en, 8'hC0, 1'b0);
            adv($sformatf("blink%0d", n));
            if (n == 20) u_if.msg_req = 1'b1;
            if (n == 25) u_if.edit_req = 1'b0;
        end

        // Msg takes over at the next boundary.
        push(3'b010, 1'b1, 4'b1110, 8'hC0, 1'b1);
        push(3'b010, 1'b0, 4'b1101, 8'hF9, 1'b1);
        push(3'b010, 1'b0, 4'b1011, 8'hA4, 1'b1);
        push(3'b010, 1'b0, 4'b0111, 8'hB0, 1'b1);
        adv("msg0");
        adv("msg1");
        u_if.msg_req  = 1'b0;
        u_if.time_req = 1'b0;
        adv("msg2");
        adv("msg3");

        // No owner, then edit re-requested on digit 1 with edit_sel = 1.
        for (int n = 32; n <= 45; n++) begin
            if (n < 36) begin
                push(3'b000, n == 32, 4'hF, 8'hFF, 1'b1);
            end else begin
                m   = n - 36;
                dig = m % 4;
                ph  = ((4 * m) / 10) % 2 == 1;
                en  = ~(4'b0001 << dig);
                if (ph && dig == 1) en = 4'hF;
                push(3'b100, dig == 0, en, 8'hC0, 1'b0);
            end
            adv($sformatf("reedit%0d", n));
            if (n == 33) begin
                u_if.edit_sel = 2'd1;
                u_if.edit_req = 1'b1;
            end
        end

        // Asynchronous reset between clock edges, mid-frame.
        repeat (2) tick();
        #2;
        M_RESET_N = 1'b0;
        #1;
        chk("arst.sseg", 32'(IO_SSEG), 32'h0FF);
        chk("arst.ssegd", 32'(IO_SSEGD), 32'hF);
        chk("arst.col", 32'(IO_SSEG_COL), 32'd1);
        chk("arst.grant", 32'(u_if.grant), 32'd0);
        chk("arst.fd", 32'(u_if.frame_done), 32'd0);
        #1;
        M_RESET_N = 1'b1;
        repeat (3) tick();
        chk("arst.early_fd", 32'(u_if.frame_done), 32'd0);
        chk("arst.early_ssegd", 32'(IO_SSEGD), 32'hF);
        push(3'b100, 1'b1, 4'b1110, 8'hC0, 1'b0);
        tick();
        pop_check("arst.first");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
